// File: rtl/spi_ram_ctrl.sv
// Byte RAM behind the SPI slave: decodes 10-bit command words into address loads,
// auto-incrementing writes and reads, and returns read bytes with a one-cycle strobe.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {IDLE, RD_RESP} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
  logic [7:0]             mem [MEM_DEPTH];
  logic [1:0]             opcode;
  logic [7:0]             payload;
  logic                   cmd_wr_addr, cmd_wr_data, cmd_rd_addr, cmd_rd_data;

  assign opcode      = din[9:8];
  assign payload     = din[7:0];
  assign cmd_wr_addr = rx_valid && (opcode == 2'b00);
  assign cmd_wr_data = rx_valid && (opcode == 2'b01);
  assign cmd_rd_addr = rx_valid && (opcode == 2'b10);
  assign cmd_rd_data = rx_valid && (opcode == 2'b11);

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return 32'(a) < MEM_DEPTH;
  endfunction

  // Anything at or past the last word (including out-of-range addresses) wraps to 0.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (32'(a) >= MEM_DEPTH - 1) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (cmd_rd_data) state_nxt = RD_RESP;
  end

  assign tx_valid = (state == RD_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
      dout    <= 8'h00;
    end else begin
      if (cmd_wr_addr) wr_addr <= payload;
      if (cmd_wr_data) wr_addr <= next_addr(wr_addr);
      if (cmd_rd_addr) rd_addr <= payload;
      if (cmd_rd_data) begin
        dout    <= in_range(rd_addr) ? mem[rd_addr[IDX_W-1:0]] : 8'h00;
        rd_addr <= next_addr(rd_addr);
      end
    end
  end

  // Storage is never cleared; writes past MEM_DEPTH are dropped.
  always_ff @(posedge clk) begin
    if (cmd_wr_data && in_range(wr_addr)) mem[wr_addr[IDX_W-1:0]] <= payload;
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomised scoreboard bench for spi_ram_ctrl: a 256-deep and a 16-deep instance
// driven against an array-based reference model of the command set.
module tb_spi_ram_ctrl;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din      [2];
  logic       rx_valid [2];
  logic [7:0] dout     [2];
  logic       tx_valid [2];

  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;
  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] last [2];
  logic [7:0] mm   [2][256];
  int         wa   [2];
  int         ra   [2];

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din[0]), .rx_valid(rx_valid[0]),
    .dout(dout[0]), .tx_valid(tx_valid[0])
  );

  spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(8)) dut16 (
    .clk(clk), .rst(rst), .din(din[1]), .rx_valid(rx_valid[1]),
    .dout(dout[1]), .tx_valid(tx_valid[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int depth(input bit d);
    return d ? 16 : 256;
  endfunction

  // Reference model: applied right after the edge that consumed the command.
  task automatic model(input bit d, input logic [1:0] op, input logic [7:0] p);
    exp_t e;
    case (op)
      2'b00: wa[d] = int'(p);
      2'b01: begin
        if (wa[d] < depth(d)) mm[d][8'(wa[d])] = p;
        wa[d] = (wa[d] < depth(d) - 1) ? wa[d] + 1 : 0;
      end
      2'b10: ra[d] = int'(p);
      default: begin
        e.d = (ra[d] < depth(d)) ? mm[d][8'(ra[d])] : 8'h00;
        e.c = cyc;
        if (d) q1.push_back(e); else q0.push_back(e);
        ra[d] = (ra[d] < depth(d) - 1) ? ra[d] + 1 : 0;
      end
    endcase
  endtask

  task automatic cmd(input bit d, input logic [1:0] op, input logic [7:0] p);
    din[d]       = {op, p};
    rx_valid[d]  = 1'b1;
    rx_valid[!d] = 1'b0;
    @(posedge clk);
    #1;
    model(d, op, p);
  endtask

  task automatic idle(input int n);
    rx_valid[0] = 1'b0;
    rx_valid[1] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (dout[i] !== 8'h00 || tx_valid[i] !== 1'b0) begin
        nerr++;
        $display("FAIL %s dut%0d: dout=%h tx_valid=%b, required dout=00 tx_valid=0",
                 tag, i, dout[i], tx_valid[i]);
      end
    end
  endtask

  task automatic mon(input bit d);
    exp_t e;
    nvec++;
    if (tx_valid[d] === 1'b1) begin
      if ((d ? q1.size() : q0.size()) == 0) begin
        nerr++;
        $display("FAIL unexpected_tx dut%0d cyc=%0d: tx_valid=1 dout=%h, required tx_valid=0",
                 d, cyc, dout[d]);
      end else begin
        e = d ? q1.pop_front() : q0.pop_front();
        if (dout[d] !== e.d || cyc != e.c) begin
          nerr++;
          $display("FAIL read_data dut%0d: dout=%h at cyc %0d, required %h at cyc %0d",
                   d, dout[d], cyc, e.d, e.c);
        end
      end
      last[d] = dout[d];
    end else if (tx_valid[d] !== 1'b0 || dout[d] !== last[d]) begin
      nerr++;
      $display("FAIL dout_hold dut%0d cyc=%0d: dout=%h tx_valid=%b, required dout=%h tx_valid=0",
               d, cyc, dout[d], tx_valid[d], last[d]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  initial begin
    bit         d;
    logic [1:0] op;
    logic [7:0] p;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; rx_valid[i] = 1'b0; last[i] = 8'h00; wa[i] = 0; ra[i] = 0;
    end
    #2;
    chk_rst("reset_initial");
    #20 rst = 1'b0;

    // Give every location a known value.
    for (int k = 0; k < 2; k++) begin
      d = 1'(k);
      cmd(d, 2'b00, 8'h00);
      for (int i = 0; i < depth(d); i++) cmd(d, 2'b01, 8'($urandom_range(0, 255)));
    end
    idle(2);

    // Single write/read, then hold dout for more than 8 cycles.
    cmd(1'b0, 2'b00, 8'h10); cmd(1'b0, 2'b01, 8'hA5);
    cmd(1'b0, 2'b10, 8'h10); cmd(1'b0, 2'b11, 8'h00);
    idle(10);

    // Burst write and burst read.
    cmd(1'b0, 2'b00, 8'h20);
    cmd(1'b0, 2'b01, 8'h11); cmd(1'b0, 2'b01, 8'h22); cmd(1'b0, 2'b01, 8'h33);
    cmd(1'b0, 2'b10, 8'h20);
    cmd(1'b0, 2'b11, 8'h00); cmd(1'b0, 2'b11, 8'h00); cmd(1'b0, 2'b11, 8'h00);
    idle(9);

    // Wrap from the last word back to 0.
    cmd(1'b0, 2'b00, 8'hFF); cmd(1'b0, 2'b01, 8'h5A); cmd(1'b0, 2'b01, 8'hC3);
    cmd(1'b0, 2'b10, 8'hFF); cmd(1'b0, 2'b11, 8'h00); cmd(1'b0, 2'b11, 8'h00);
    idle(9);

    // Out-of-range on the 16-deep instance, then read back the whole array.
    cmd(1'b1, 2'b00, 8'h14); cmd(1'b1, 2'b01, 8'h77);
    cmd(1'b1, 2'b10, 8'h14); cmd(1'b1, 2'b11, 8'h00);
    idle(9);
    cmd(1'b1, 2'b10, 8'h00);
    for (int i = 0; i < 16; i++) cmd(1'b1, 2'b11, 8'h00);
    idle(9);

    // Held rx_valid: two writes, read-after-write, then held non-read opcodes.
    cmd(1'b0, 2'b00, 8'h50); cmd(1'b0, 2'b10, 8'h51);
    cmd(1'b0, 2'b01, 8'h3C); cmd(1'b0, 2'b01, 8'h3D); cmd(1'b0, 2'b11, 8'h00);
    for (int i = 0; i < 8; i++) cmd(1'b0, 2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)));
    idle(9);

    // Reset while a read response is on the output.
    cmd(1'b0, 2'b10, 8'h30); cmd(1'b0, 2'b11, 8'h00);
    rst = 1'b1;
    q0.delete(); q1.delete();
    #1;
    chk_rst("reset_async");
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last[i] = 8'h00; wa[i] = 0; ra[i] = 0;
    end
    idle(3);
    cmd(1'b0, 2'b11, 8'h00); cmd(1'b1, 2'b11, 8'h00);
    idle(9);

    // Randomised command mix across both instances.
    repeat (1500) begin
      d  = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      p  = d ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      cmd(d, op, p);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(10);

    nvec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      nerr++;
      $display("FAIL missing_tx: pending reads dut0=%0d dut16=%0d, required 0 and 0",
               q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Single-port byte RAM with a command decoder. It sits directly downstream of the SPI slave: it consumes each 10-bit command word the slave delivers with its one-cycle valid strobe, and returns read bytes to the slave's transmit path. Command opcode is din[9:8] and the payload is din[7:0]. The address registers auto-increment, so the host can perform burst writes and burst reads without resending the address.

Parameters:
MEM_DEPTH, 256, number of 8-bit words; legal range 1..256.
ADDR_SIZE, 8, width of the address registers; fixed at 8 because the payload is 8 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  10  command word from the SPI slave; [9:8] is the opcode, [7:0] is the payload.
rx_valid  input  1  din is valid this cycle; normally a one-cycle pulse.
dout  output  8  read data to the SPI slave transmit path.
tx_valid  output  1  one-cycle pulse marking that dout holds new read data.

Behaviour:
- Reset (rst=1, asynchronous): wr_addr=0, rd_addr=0, dout=8'h00, tx_valid=0.
  - Memory contents are not cleared and are undefined until written.
  - Reset asserted mid-operation aborts any pending read. No tx_valid pulse is emitted after reset releases.
- The command is decoded only in cycles where rx_valid=1. Every cycle with rx_valid=1 is a separate command, including when rx_valid is held high.
- Opcode 2'b00, write address: wr_addr <= din[7:0]. No other state changes.
- Opcode 2'b01, write data:
  - mem[wr_addr] <= din[7:0].
  - wr_addr then increments; it wraps from MEM_DEPTH-1 to 0.
- Opcode 2'b10, read address: rd_addr <= din[7:0]. No output change.
- Opcode 2'b11, read data:
  - Payload din[7:0] is ignored.
  - On the next edge: dout <= mem[rd_addr] and tx_valid <= 1.
  - rd_addr then increments, with the same wrap rule as wr_addr.
  - Latency is 1 cycle from the rx_valid edge to tx_valid high.
- tx_valid is high for exactly one cycle per read-data command and is otherwise 0.
- dout holds its value until the next read-data command. The SPI slave shifts dout out over the following 8 cycles, so dout must not change in that window.
- Out-of-range addresses (address >= MEM_DEPTH, possible only when MEM_DEPTH < 256):
  - A write to such an address is discarded, but wr_addr still increments, wrapping to 0.
  - A read from such an address returns dout=8'h00 with a normal tx_valid pulse.
- Read-after-write to the same address in back-to-back rx_valid cycles returns the newly written byte, because the write commits on the earlier edge.
- Internal FSM:
  - States: IDLE, RD_RESP.
  - IDLE goes to RD_RESP when rx_valid=1 and opcode is 11. In RD_RESP, tx_valid=1.
  - RD_RESP returns to IDLE after one cycle.
  - If a new command arrives during RD_RESP, it is decoded normally in that cycle. A second read-data command keeps the FSM in RD_RESP, gives a second tx_valid pulse, and updates dout.
- rx_valid=0: no state change apart from the FSM returning to IDLE.

Test Plan:
- Reset check: assert rst mid-run -> dout=00 and tx_valid=0 immediately (asynchronous); after release, read-data with no read address set returns mem[0].
- Single write/read: din=00_0x10, then 01_0xA5, then 10_0x10, then 11_xx -> tx_valid pulses once, 1 cycle after the last command, with dout=A5; dout stays A5 for at least 8 cycles.
- Burst and auto-increment: write address 0x20, then data 11, 22, 33; read address 0x20; three read-data commands -> dout sequence 11, 22, 33, with one tx_valid pulse each.
- Wrap-around at the default depth: write address 0xFF, then data 0x5A and 0xC3 -> mem[255]=5A, mem[0]=C3; reading from 0xFF twice returns 5A then C3.
- Out-of-range with MEM_DEPTH=16: write address 0x14, data 0x77 -> memory unchanged; read address 0x14, read-data -> dout=00 with tx_valid pulsed.
- Back-to-back commands: rx_valid held 2 cycles with din=01_0x3C, then read-data at the same address on the next cycle -> dout=3C; rx_valid held high with a non-read opcode -> tx_valid stays 0.
